// File: rtl/uar_tx.sv
// UART transmit serializer: valid/ready word in, registered serial line out.
// Frame = start bit, DATA_BITS data bits LSB first, optional parity, STOP_BITS stop bits.
module uar_tx #(
   parameter int CLK_DIV    = 868,
   parameter int DATA_BITS  = 8,
   parameter int PARITY_EN  = 0,
   parameter int PARITY_ODD = 0,
   parameter int STOP_BITS  = 1
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic [DATA_BITS-1:0] tx_data_i,
   input  logic                 tx_valid_i,
   output logic                 tx_ready_o,
   output logic                 tx_out_o,
   output logic                 tx_busy_o
);

   localparam int BAUD_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int BIT_W  = 4;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_PARITY = 3'd3,
      S_STOP   = 3'd4
   } state_e;

   state_e               state_q, state_d;
   logic [BAUD_W-1:0]    baud_q, baud_d;
   logic [BIT_W-1:0]     bit_q, bit_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic                 par_q, par_d;
   logic                 tx_q, tx_d;

   logic xfer, bit_end, last_data, last_stop;

   assign xfer      = tx_valid_i & (state_q == S_IDLE);
   assign bit_end   = (baud_q == BAUD_W'(CLK_DIV - 1));
   assign last_data = (bit_q == BIT_W'(DATA_BITS - 1));
   assign last_stop = (bit_q == BIT_W'(STOP_BITS - 1));

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= S_IDLE;
         baud_q  <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         par_q   <= 1'b0;
         tx_q    <= 1'b1;
      end else begin
         state_q <= state_d;
         baud_q  <= baud_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         par_q   <= par_d;
         tx_q    <= tx_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:   if (xfer) state_d = S_START;
         S_START:  if (bit_end) state_d = S_DATA;
         S_DATA:   if (bit_end && last_data) state_d = (PARITY_EN != 0) ? S_PARITY : S_STOP;
         S_PARITY: if (bit_end) state_d = S_STOP;
         S_STOP:   if (bit_end && last_stop) state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   // Datapath next-state; the bit counter is reused to count stop bits.
   always_comb begin
      baud_d  = bit_end ? '0 : baud_q + 1'b1;
      bit_d   = bit_q;
      shift_d = shift_q;
      par_d   = par_q;
      if (state_q == S_IDLE) begin
         baud_d = '0;
         bit_d  = '0;
         if (xfer) begin
            shift_d = tx_data_i;
            par_d   = (^tx_data_i) ^ (PARITY_ODD != 0);
         end
      end else if (bit_end) begin
         if (state_q == S_DATA) begin
            shift_d = shift_q >> 1;
            bit_d   = last_data ? '0 : bit_q + 1'b1;
         end else if (state_q == S_STOP) begin
            bit_d = last_stop ? '0 : bit_q + 1'b1;
         end
      end
   end

   // Line value is derived from the next state so the register changes only at bit boundaries.
   always_comb begin
      case (state_d)
         S_START:  tx_d = 1'b0;
         S_DATA:   tx_d = shift_d[0];
         S_PARITY: tx_d = par_d;
         default:  tx_d = 1'b1;
      endcase
      tx_ready_o = (state_q == S_IDLE);
      tx_busy_o  = (state_q != S_IDLE);
      tx_out_o   = tx_q;
   end

endmodule
